// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, optional 2-entry skid buffer and NOP control on bubbles
module pipe_stage_reg #(
    parameter int                DATA_W   = 32,
    parameter int                CTRL_W   = 7,
    parameter bit                SKID     = 1'b1,
    parameter logic [DATA_W-1:0] DATA_RST = '0,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
    state_t            r_state;
    logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl;
    logic [DATA_W-1:0] r_main_data, r_skid_data;
    logic              w_in_fire, w_out_fire;
    // with the skid buffer, ready depends only on registered state; otherwise a full stage accepts when it drains
    assign ready_o    = SKID ? (r_state != TWO) : (r_state == EMPTY || ready_i);
    assign valid_o    = (r_state != EMPTY);
    assign ctrl_o     = valid_o ? r_main_ctrl : CTRL_NOP;
    assign data_o     = r_main_data;
    assign occ_o      = r_state;
    assign w_in_fire  = valid_i && ready_o;
    assign w_out_fire = valid_o && ready_i;
    // occupancy FSM and entry registers; flush discards held entries and any input firing this cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= EMPTY;
            r_main_ctrl <= CTRL_NOP;
            r_skid_ctrl <= CTRL_NOP;
            r_main_data <= DATA_RST;
            r_skid_data <= DATA_RST;
        end else if (flush_i) begin
            r_state <= EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_in_fire) begin
                    r_main_ctrl <= ctrl_i;
                    r_main_data <= data_i;
                    r_state     <= ONE;
                end
                ONE: if (w_in_fire && (w_out_fire || !SKID)) begin
                    r_main_ctrl <= ctrl_i;
                    r_main_data <= data_i;
                end else if (w_in_fire) begin
                    r_skid_ctrl <= ctrl_i;
                    r_skid_data <= data_i;
                    r_state     <= TWO;
                end else if (w_out_fire) begin
                    r_state <= EMPTY;
                end
                TWO: if (w_out_fire) begin
                    r_main_ctrl <= r_skid_ctrl;
                    r_main_data <= r_skid_data;
                    r_state     <= ONE;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg with SKID=1 and SKID=0 side by side
module tb_pipe_stage_reg;
    localparam logic [31:0] DRST = 32'hDEAD_BEEF;
    localparam logic [6:0]  NOP  = 7'h55;
    logic        clk = 1'b0;
    logic        rst_n, valid_in, ready_in, flush;
    logic [31:0] din;
    logic [6:0]  cin;
    logic        vo[2], rdy[2];
    logic [6:0]  co[2];
    logic [31:0] dout[2];
    logic [1:0]  occ[2];
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(7), .SKID(1'b1), .DATA_RST(DRST), .CTRL_NOP(NOP)) u_skid (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_in), .ready_o(rdy[1]), .ctrl_i(cin), .data_i(din),
        .flush_i(flush), .valid_o(vo[1]), .ready_i(ready_in), .ctrl_o(co[1]), .data_o(dout[1]), .occ_o(occ[1]));

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(7), .SKID(1'b0), .DATA_RST(DRST), .CTRL_NOP(NOP)) u_single (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_in), .ready_o(rdy[0]), .ctrl_i(cin), .data_i(din),
        .flush_i(flush), .valid_o(vo[0]), .ready_i(ready_in), .ctrl_o(co[0]), .data_o(dout[0]), .occ_o(occ[0]));

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
        else passed++;
    endfunction

    // control words always have bit 0 clear, so they can never alias the NOP word
    task automatic drv(input logic v, input logic [31:0] d);
        valid_in = v;
        din      = d;
        cin      = {d[5:0], 1'b0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard per instance: expected entries queued on accept, popped and compared on output handshake
    for (genvar g = 0; g < 2; g++) begin : mon
        logic [38:0] q[$];
        logic [38:0] prev;
        logic        hold = 1'b0;
        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                hold <= 1'b0;
            end else begin
                chk($sformatf("occ%0d", g), 64'(occ[g]), 64'(q.size()));
                chk($sformatf("valid%0d", g), 64'(vo[g]), 64'(q.size() != 0));
                chk($sformatf("ready%0d", g), 64'(rdy[g]), g ? 64'(q.size() != 2) : 64'(q.size() == 0 || ready_in));
                if (!vo[g]) chk($sformatf("nop%0d", g), 64'(co[g]), 64'(NOP));
                if (hold) chk($sformatf("stable%0d", g), 64'({co[g], dout[g]}), 64'(prev));
                if (vo[g] && ready_in) begin
                    chk($sformatf("out%0d", g), 64'({co[g], dout[g]}), q.size() != 0 ? 64'(q[0]) : 64'(~{co[g], dout[g]}));
                    if (q.size() != 0) void'(q.pop_front());
                end
                if (flush) q.delete();
                else if (valid_in && rdy[g]) q.push_back({cin, din});
                hold <= vo[g] && !ready_in && !flush;
                prev <= {co[g], dout[g]};
            end
        end
    end

    task automatic chk_idle(input string n);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_valid%0d", n, i), 64'(vo[i]), 64'(0));
            chk($sformatf("%s_occ%0d", n, i), 64'(occ[i]), 64'(0));
            chk($sformatf("%s_ctrl%0d", n, i), 64'(co[i]), 64'(NOP));
        end
    endtask

    initial begin
        rst_n = 1'b0; ready_in = 1'b0; flush = 1'b0;
        drv(1'b0, 32'h0);
        repeat (2) step();
        @(negedge clk);
        chk_idle("reset");
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_ready%0d", i), 64'(rdy[i]), 64'(1));
            chk($sformatf("reset_data%0d", i), 64'(dout[i]), 64'(DRST));
        end
        step();
        rst_n = 1'b1;
        // streaming: data_o follows data_i one cycle later with no gaps
        ready_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            drv(1'b1, 32'(k));
            @(negedge clk);
            if (k > 1) for (int i = 0; i < 2; i++) begin
                chk($sformatf("stream_data%0d", i), 64'(dout[i]), 64'(k - 1));
                chk($sformatf("stream_occ%0d", i), 64'(occ[i]), 64'(1));
            end
            step();
        end
        drv(1'b0, 32'h0);
        @(negedge clk);
        chk("stream_last", 64'(dout[1]), 64'(8));
        step();
        @(negedge clk);
        chk_idle("drain");
        chk("drain_hold_data", 64'(dout[0]), 64'(8));
        step();
        // backpressure: skid instance absorbs A and B, single instance holds A
        ready_in = 1'b0;
        drv(1'b1, 32'hA0);
        step();
        drv(1'b1, 32'hB0);
        @(negedge clk);
        chk("bp_occ1", 64'(occ[1]), 64'(1));
        chk("bp_ready1", 64'(rdy[1]), 64'(1));
        chk("bp_ready0", 64'(rdy[0]), 64'(0));
        step();
        drv(1'b0, 32'h0);
        @(negedge clk);
        chk("bp_full_occ1", 64'(occ[1]), 64'(2));
        chk("bp_full_ready1", 64'(rdy[1]), 64'(0));
        chk("bp_full_data1", 64'(dout[1]), 64'hA0);
        chk("bp_data0", 64'(dout[0]), 64'hA0);
        step();
        ready_in = 1'b1;
        @(negedge clk);
        chk("bp_release_a", 64'(dout[1]), 64'hA0);
        step();
        @(negedge clk);
        chk("bp_release_b", 64'(dout[1]), 64'hB0);
        chk("bp_release_occ1", 64'(occ[1]), 64'(1));
        chk("bp_single_empty", 64'(vo[0]), 64'(0));
        step();
        @(negedge clk);
        chk("bp_done", 64'(vo[1]), 64'(0));
        // single-entry stall then replace in one cycle
        ready_in = 1'b0;
        drv(1'b1, 32'hC0);
        step();
        drv(1'b1, 32'hD0);
        @(negedge clk);
        chk("stall_ready0", 64'(rdy[0]), 64'(0));
        chk("stall_data0", 64'(dout[0]), 64'hC0);
        ready_in = 1'b1;
        #1;
        chk("stall_ready0_comb", 64'(rdy[0]), 64'(1));
        step();
        drv(1'b0, 32'h0);
        @(negedge clk);
        chk("replace_data0", 64'(dout[0]), 64'hD0);
        chk("replace_occ0", 64'(occ[0]), 64'(1));
        chk("replace_data1", 64'(dout[1]), 64'hD0);
        step();
        // flush with skid full and an input firing into the single-entry instance
        ready_in = 1'b0;
        drv(1'b1, 32'hE0);
        step();
        drv(1'b1, 32'hF0);
        step();
        drv(1'b1, 32'h6C);
        flush = 1'b1;
        ready_in = 1'b1;
        @(negedge clk);
        chk("flush_pre_occ1", 64'(occ[1]), 64'(2));
        step();
        flush = 1'b0;
        drv(1'b0, 32'h0);
        @(negedge clk);
        chk_idle("flush");
        for (int n = 0; n < 3; n++) begin
            step();
            @(negedge clk);
            chk("flush_no_g0", 64'(vo[0]), 64'(0));
            chk("flush_no_g1", 64'(vo[1]), 64'(0));
        end
        step();
        // random traffic: the scoreboards check order, occupancy, ready and hold stability
        for (int n = 0; n < 10000; n++) begin
            drv($urandom_range(0, 9) < 7, $urandom);
            ready_in = $urandom_range(0, 9) < 7;
            flush    = $urandom_range(0, 19) == 0;
            step();
        end
        // asynchronous reset with the skid buffer full
        flush = 1'b1;
        valid_in = 1'b0;
        step();
        flush = 1'b0;
        ready_in = 1'b0;
        drv(1'b1, 32'h11);
        step();
        drv(1'b1, 32'h22);
        step();
        valid_in = 1'b0;
        chk("midrst_pre_occ1", 64'(occ[1]), 64'(2));
        rst_n = 1'b0;
        #1;
        chk_idle("midrst");
        for (int i = 0; i < 2; i++) chk($sformatf("midrst_data%0d", i), 64'(dout[i]), 64'(DRST));
        step();
        rst_n = 1'b1;
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 32'(k + 100));
            step();
        end
        valid_in = 1'b0;
        repeat (3) step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
